// File: rtl/image_pkg.sv
// rtl/image_pkg.sv - shared state encoding and frame geometry defaults for the frame writer and readout
package image_pkg;

  localparam int IMG_W_DEFAULT       = 320;
  localparam int IMG_H_DEFAULT       = 240;
  localparam int DATA_W_DEFAULT      = 16;
  localparam int BANK_OFFSET_DEFAULT = 76800;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  function automatic int pix_count(input int w, input int h);
    return w * h;
  endfunction

endpackage

// File: rtl/sync_pixel_fifo.sv
// rtl/sync_pixel_fifo.sv - synchronous skid FIFO between camera beats and the SRAM write engine
// Ports: clk, rst (sync, active-high); push/push_data in; pop in, pop_data out (head entry,
//        valid while !empty); full, empty, count status.
module sync_pixel_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
    do_push  = push && ((count_q != FULL_CNT) || do_pop);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign count    = count_q;

endmodule

// File: rtl/image_frame_writer.sv
// rtl/image_frame_writer.sv - captures camera frames into SRAM, optional ping-pong between two banks
// Ports: wclk, rst (sync, active-high); enable, continuous control; cam_addr/cam_data/cam_we camera
//        beats in; sram_sel/sram_we/sram_oe/sram_data/sram_addr SRAM write port out;
//        busy, done, done_bank, overflow status out.
module image_frame_writer
  import image_pkg::*;
#(
  parameter int IMG_W       = IMG_W_DEFAULT,
  parameter int IMG_H       = IMG_H_DEFAULT,
  parameter int DATA_W      = DATA_W_DEFAULT,
  parameter int CAM_ADDR_W  = 17,
  parameter int SRAM_ADDR_W = 19,
  parameter int FIFO_DEPTH  = 4,
  parameter int WR_CYCLES   = 2,
  parameter int BANK_OFFSET = BANK_OFFSET_DEFAULT
) (
  input  logic                   wclk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   continuous,
  input  logic [CAM_ADDR_W-1:0]  cam_addr,
  input  logic [DATA_W-1:0]      cam_data,
  input  logic                   cam_we,
  output logic                   sram_sel,
  output logic                   sram_we,
  output logic                   sram_oe,
  output logic [DATA_W-1:0]      sram_data,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic                   busy,
  output logic                   done,
  output logic                   done_bank,
  output logic                   overflow
);

  localparam int                     PIX_COUNT  = pix_count(IMG_W, IMG_H);
  localparam logic [CAM_ADDR_W-1:0]  LAST_IDX   = CAM_ADDR_W'(PIX_COUNT - 1);
  localparam logic [SRAM_ADDR_W-1:0] BANK1_BASE = SRAM_ADDR_W'(BANK_OFFSET);
  localparam int                     PH_W       = $clog2(WR_CYCLES + 1);
  localparam logic [PH_W-1:0]        PH_LAST_WE = PH_W'(WR_CYCLES - 1);
  localparam logic [PH_W-1:0]        PH_GAP     = PH_W'(WR_CYCLES);
  localparam int                     ENTRY_W    = CAM_ADDR_W + DATA_W;

  state_e                 state_q, state_d;
  logic                   bank_q, bank_d;
  logic                   overflow_q, overflow_d;
  logic                   eng_active_q, eng_active_d;
  logic [PH_W-1:0]        ph_q, ph_d;
  logic                   we_q, we_d;
  logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]      data_q, data_d;

  logic                   push, pop, drop;
  logic [ENTRY_W-1:0]     pop_data;
  logic                   fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                   beat_first, beat_in_range, beat_last;
  logic                   eng_free, eng_en;

  sync_pixel_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (wclk),
    .rst       (rst),
    .push      (push),
    .push_data ({cam_addr, cam_data}),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign beat_first    = cam_we && (cam_addr == '0);
  assign beat_in_range = cam_we && (cam_addr <= LAST_IDX);
  assign beat_last     = cam_we && (cam_addr == LAST_IDX);
  // The gap cycle already counts as free so the next entry loads right behind it.
  assign eng_free      = !eng_active_q || (ph_q == PH_GAP);
  assign eng_en        = (state_q == ST_ARM) || (state_q == ST_CAPTURE) || (state_q == ST_DRAIN);
  assign pop           = eng_en && eng_free && !fifo_empty;

  always_ff @(posedge wclk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (!enable)         state_d = ST_IDLE;
        else if (beat_first) state_d = beat_last ? ST_DRAIN : ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (beat_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if ((fifo_count == '0) && eng_free) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = (continuous && enable) ? ST_ARM : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    push = 1'b0;
    if (state_q == ST_ARM)     push = enable && beat_first;
    if (state_q == ST_CAPTURE) push = beat_in_range;
    drop      = push && fifo_full && !pop;
    busy      = (state_q == ST_ARM) || (state_q == ST_CAPTURE);
    done      = (state_q == ST_DONE);
    done_bank = done && bank_q;
  end

  always_comb begin
    bank_d = bank_q;
    if ((state_q == ST_DONE) && continuous && enable) bank_d = ~bank_q;

    overflow_d = overflow_q;
    if ((state_q == ST_IDLE) && enable) overflow_d = 1'b0;
    else if (drop)                      overflow_d = 1'b1;

    eng_active_d = eng_active_q;
    ph_d         = ph_q;
    we_d         = we_q;
    addr_d       = addr_q;
    data_d       = data_q;
    if (eng_active_q) begin
      if (ph_q == PH_GAP) eng_active_d = 1'b0;
      else                ph_d = ph_q + PH_W'(1);
      if (ph_q == PH_LAST_WE) we_d = 1'b0;
    end
    if (pop) begin
      eng_active_d = 1'b1;
      ph_d         = '0;
      we_d         = 1'b1;
      addr_d       = (bank_q ? BANK1_BASE : '0) + SRAM_ADDR_W'(pop_data[ENTRY_W-1:DATA_W]);
      data_d       = pop_data[DATA_W-1:0];
    end
  end

  always_ff @(posedge wclk) begin
    if (rst) begin
      bank_q       <= 1'b0;
      overflow_q   <= 1'b0;
      eng_active_q <= 1'b0;
      ph_q         <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
    end else begin
      bank_q       <= bank_d;
      overflow_q   <= overflow_d;
      eng_active_q <= eng_active_d;
      ph_q         <= ph_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
    end
  end

  assign sram_sel  = we_q;
  assign sram_we   = we_q;
  assign sram_oe   = 1'b0;
  assign sram_addr = addr_q;
  assign sram_data = data_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_image_frame_writer.sv
// tb/tb_image_frame_writer.sv - self-checking bench for image_frame_writer
module tb_image_frame_writer;

  localparam int W    = 4;
  localparam int H    = 2;
  localparam int DW   = 16;
  localparam int CAW  = 4;
  localparam int SAW  = 8;
  localparam int DEP  = 2;
  localparam int WRC  = 2;
  localparam int BOFF = 100;
  localparam int NPIX = W * H;

  logic           wclk = 1'b0;
  logic           rst, enable, continuous, cam_we;
  logic [CAW-1:0] cam_addr;
  logic [DW-1:0]  cam_data;
  logic           sram_sel, sram_we, sram_oe, busy, done, done_bank, overflow;
  logic [DW-1:0]  sram_data;
  logic [SAW-1:0] sram_addr;

  image_frame_writer #(
    .IMG_W(W), .IMG_H(H), .DATA_W(DW), .CAM_ADDR_W(CAW), .SRAM_ADDR_W(SAW),
    .FIFO_DEPTH(DEP), .WR_CYCLES(WRC), .BANK_OFFSET(BOFF)
  ) dut (
    .wclk(wclk), .rst(rst), .enable(enable), .continuous(continuous),
    .cam_addr(cam_addr), .cam_data(cam_data), .cam_we(cam_we),
    .sram_sel(sram_sel), .sram_we(sram_we), .sram_oe(sram_oe),
    .sram_data(sram_data), .sram_addr(sram_addr),
    .busy(busy), .done(done), .done_bank(done_bank), .overflow(overflow)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    int gap;
    bit prefix;
    bit oor;
    bit exp_bank;
    bit exp_ovf;
  } row_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [SAW+DW-1:0] wq[$];
  int                first_rise;
  bit                prev_we;
  int                hi;
  logic [SAW-1:0]    cur_a;
  logic [DW-1:0]     cur_d;
  bit                stable;
  int                done_cnt = 0;
  bit                last_done_bank;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  initial forever begin
    @(posedge wclk);
    cyc++;
  end

  initial begin
    prev_we = 1'b0;
    hi      = 0;
    stable  = 1'b1;
    forever begin
      @(negedge wclk);
      if (rst) begin
        prev_we = 1'b0;
      end else begin
        if (sram_we && !prev_we) begin
          if (wq.size() == 0) first_rise = cyc;
          wq.push_back({sram_addr, sram_data});
          hi     = 1;
          cur_a  = sram_addr;
          cur_d  = sram_data;
          stable = 1'b1;
        end else if (sram_we) begin
          hi++;
          if (sram_addr !== cur_a || sram_data !== cur_d) stable = 1'b0;
        end else if (prev_we) begin
          check("strobe_width", hi, WRC);
          check("strobe_stable", longint'(stable && sram_addr === cur_a && sram_data === cur_d), 1);
        end
        if (sram_sel !== sram_we || sram_oe !== 1'b0) stable = 1'b0;
        if (done) begin
          done_cnt++;
          last_done_bank = done_bank;
        end
        prev_we = sram_we;
      end
    end
  end

  task automatic check_quiet(input string name);
    check(name, {sram_sel, sram_we, sram_oe, busy, done, done_bank, overflow, sram_addr, sram_data}, 0);
  endtask

  // Reference: once the addr-0 beat is seen, every in-range beat up to and including the
  // last pixel becomes one SRAM write at bank base + index, in arrival order.
  task automatic run_frame(input int gap, input bit prefix, input bit oor, input bit keep_en,
                           input int base, input bit exp_bank, input bit exp_ovf);
    logic [SAW+DW-1:0] expq[$];
    int                addrs[$];
    int                d0, b0cyc, g;
    bit                armed, ended;
    logic [DW-1:0]     pix;
    wq.delete();
    first_rise = -1;
    armed = 1'b0;
    ended = 1'b0;
    b0cyc = 0;
    if (prefix) begin
      addrs.push_back(5);
      addrs.push_back(6);
      addrs.push_back(7);
    end
    for (int a = 0; a < NPIX; a++) begin
      addrs.push_back(a);
      if (oor && a == 3) addrs.push_back(9);
    end
    d0 = done_cnt;
    enable = 1'b1;
    tick();
    @(negedge wclk);
    check("overflow_after_arm", overflow, 0);
    foreach (addrs[i]) begin
      pix = DW'($urandom);
      g   = (gap >= 3) ? gap + int'($urandom_range(0, 2)) : gap;
      if (addrs[i] == 0 && !armed) begin
        armed = 1'b1;
        b0cyc = cyc;
      end
      if (armed && !ended && addrs[i] < NPIX) begin
        expq.push_back({SAW'(base + addrs[i]), pix});
        if (addrs[i] == NPIX - 1) ended = 1'b1;
      end
      cam_addr = CAW'(addrs[i]);
      cam_data = pix;
      cam_we   = 1'b1;
      tick();
      cam_we = 1'b0;
      if (armed) enable = keep_en;
      repeat (g - 1) tick();
    end
    for (int i = 0; i < 400 && done_cnt == d0; i++) tick();
    repeat (6) tick();
    @(negedge wclk);
    check("done_pulses", done_cnt - d0, 1);
    check("done_bank", last_done_bank, exp_bank);
    check("overflow", overflow, exp_ovf);
    check("first_write_latency", first_rise - b0cyc, 2);
    if (exp_ovf) begin
      check("writes_below_frame", longint'(wq.size() < NPIX), 1);
    end else begin
      check("write_count", wq.size(), expq.size());
      for (int i = 0; i < expq.size() && i < wq.size(); i++)
        check("write_addr_data", wq[i], expq[i]);
    end
  endtask

  initial begin
    row_t tbl[4];
    int   d0, n0;
    tbl[0] = '{gap: 3, prefix: 1'b0, oor: 1'b0, exp_bank: 1'b0, exp_ovf: 1'b0};
    tbl[1] = '{gap: 3, prefix: 1'b1, oor: 1'b0, exp_bank: 1'b0, exp_ovf: 1'b0};
    tbl[2] = '{gap: 1, prefix: 1'b0, oor: 1'b0, exp_bank: 1'b0, exp_ovf: 1'b1};
    tbl[3] = '{gap: 4, prefix: 1'b0, oor: 1'b1, exp_bank: 1'b0, exp_ovf: 1'b0};

    rst = 1'b1; enable = 1'b0; continuous = 1'b0;
    cam_we = 1'b0; cam_addr = '0; cam_data = '0;
    tick();
    tick();
    @(negedge wclk);
    check_quiet("reset_outputs");
    rst = 1'b0;
    tick();

    for (int r = 0; r < 4; r++)
      run_frame(tbl[r].gap, tbl[r].prefix, tbl[r].oor, 1'b0, 0, tbl[r].exp_bank, tbl[r].exp_ovf);

    continuous = 1'b1;
    run_frame(3, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    run_frame(3, 1'b0, 1'b0, 1'b0, BOFF, 1'b1, 1'b0);
    continuous = 1'b0;

    wq.delete();
    enable = 1'b1;
    tick();
    for (int a = 0; a < NPIX; a++) begin
      cam_addr = CAW'(a);
      cam_data = DW'($urandom);
      cam_we   = 1'b1;
      tick();
      cam_we = 1'b0;
      enable = 1'b0;
      tick();
      tick();
      if (wq.size() >= 3) break;
    end
    check("writes_before_reset", wq.size(), 3);
    d0  = done_cnt;
    rst = 1'b1;
    tick();
    @(negedge wclk);
    check_quiet("mid_frame_reset_outputs");
    rst = 1'b0;
    n0  = wq.size();
    repeat (30) tick();
    check("no_done_after_reset", done_cnt - d0, 0);
    check("no_writes_after_reset", wq.size() - n0, 0);

    run_frame(3, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/image_frame_writer.md
Name: image_frame_writer

Overview:
Parametrised successor to the single-frame camera-to-SRAM writer. It captures one or more full camera frames into external SRAM through a small skid FIFO, with configurable frame geometry, pixel width and write-strobe length. An optional continuous ping-pong mode alternates between two SRAM banks. It sits between the camera capture block and the SRAM arbiter and signals the downstream processing stage when each frame is complete.

Parameters:
IMG_W, 320, pixels per line
IMG_H, 240, lines per frame; PIX_COUNT = IMG_W*IMG_H
DATA_W, 16, pixel width
CAM_ADDR_W, 17, camera pixel-index width; must satisfy 2**CAM_ADDR_W >= PIX_COUNT
SRAM_ADDR_W, 19, SRAM address width
FIFO_DEPTH, 4, skid FIFO entries (power of 2, at least 2)
WR_CYCLES, 2, cycles that sram_we is held high per write (at least 1)
BANK_OFFSET, 76800, SRAM base address of bank 1; bank 0 base is 0

Ports:
wclk  in  1  clock
rst  in  1  synchronous reset, active-high
enable  in  1  arm capture; sampled in IDLE and at frame end
continuous  in  1  1 = ping-pong repeat, 0 = single frame
cam_addr  in  CAM_ADDR_W  pixel index of the current beat
cam_data  in  DATA_W  pixel value
cam_we  in  1  pixel-valid strobe
sram_sel  out  1  SRAM chip select
sram_we  out  1  SRAM write strobe
sram_oe  out  1  SRAM read enable; always 0
sram_data  out  DATA_W  write data
sram_addr  out  SRAM_ADDR_W  write address
busy  out  1  high in ARM or CAPTURE
done  out  1  one-cycle pulse after the last pixel write completes
done_bank  out  1  bank just completed; valid while done=1
overflow  out  1  sticky: a beat was dropped because the FIFO was full

Behaviour:
- Reset: every output is 0, FIFO is emptied, bank=0, state=IDLE. A reset mid-frame aborts without a done pulse.
- States: IDLE, ARM, CAPTURE, DRAIN, DONE.
- IDLE: if enable=1, go to ARM next cycle and clear overflow.
- ARM: wait for a beat with cam_we=1 and cam_addr==0. That beat is pushed to the FIFO in the same cycle, and the state moves to CAPTURE.
- CAPTURE: each beat with cam_we=1 and cam_addr < PIX_COUNT pushes {cam_addr, cam_data} into the FIFO.
  - Beats with cam_addr >= PIX_COUNT are ignored.
  - A beat arriving while the FIFO is full is dropped and sets overflow.
  - Once a beat with cam_addr == PIX_COUNT-1 is pushed (or dropped), no further pushes occur and the state moves to DRAIN.
- Write engine (active in every state except IDLE and DONE):
  - When the FIFO is non-empty and the engine is idle, pop one entry.
  - sram_addr = bank_base + zero-extended index, where bank_base = bank ? BANK_OFFSET : 0. sram_data = pixel.
  - Drive sram_sel=sram_we=1 for exactly WR_CYCLES cycles, then one gap cycle with sram_sel=sram_we=0.
  - addr and data stay stable for the whole WR_CYCLES+1 window.
  - Throughput: one pixel per WR_CYCLES+1 cycles.
  - Pop and push in the same cycle are both legal, including when the FIFO is full (the pop frees a slot first).
- DRAIN: when the FIFO is empty and the engine is idle, go to DONE.
- DONE (one cycle):
  - done=1 and done_bank=bank.
  - If continuous=1 and enable=1: toggle bank and go to ARM.
  - Otherwise go to IDLE; bank is retained.
- Deasserting enable in ARM returns to IDLE. Deasserting it during CAPTURE or DRAIN has no effect: the frame completes.
- Latency: from the cam_we beat to sram_we rising is 2 cycles when the FIFO is empty (1 cycle push, 1 cycle pop/register).

Decomposition:
- Package image_pkg holds:
  - the state enum encoding;
  - the PIX_COUNT function;
  - the default geometry constants (IMG_W, IMG_H, DATA_W, BANK_OFFSET) shared with the readout block.
- Sub-module sync_pixel_fifo: parametrised width and depth, synchronous reset, with push, pop, full, empty and count outputs.

Test Plan:
- Single frame, IMG_W=4, IMG_H=2, WR_CYCLES=2, cam_we every 3rd cycle, addr 0..7 → 8 writes to addresses 0..7, each strobe 2 cycles wide; done pulses once with done_bank=0; overflow=0.
- ARM sync: beats at addr 5,6,7, then 0..7 → no SRAM write before addr 0; exactly 8 writes follow.
- Overflow: FIFO_DEPTH=2, cam_we every cycle for a full frame → overflow=1 and the number of writes is less than 8; done still pulses after the frame end; the next arm clears overflow.
- Continuous, BANK_OFFSET=100, two frames → first frame writes to 0..7 with done_bank=0; second writes to 100..107 with done_bank=1.
- Reset mid-CAPTURE after 3 writes → next cycle all outputs 0; no done pulse; a new enable restarts at bank 0.
- Out-of-range beat cam_addr=9 during CAPTURE → ignored, and no SRAM write occurs.
